// File: rtl/mem_stage.sv
// MIPS MEM stage with MEM/WB pipeline register: word-addressed data memory with
// configurable wait states, upstream stall while an access is in flight.
module mem_stage #(
  parameter int unsigned ADDR_W  = 8,
  parameter int unsigned LATENCY = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [1:0]  ctlwb_in,
  input  logic [1:0]  ctlm_in,
  input  logic [31:0] alu_result_in,
  input  logic [31:0] rdata2_in,
  input  logic [4:0]  muxout_in,
  output logic        stall_out,
  output logic [1:0]  ctlwb_out,
  output logic [31:0] read_data_out,
  output logic [31:0] alu_result_out,
  output logic [4:0]  muxout_out,
  output logic        misalign_out
);

  localparam int unsigned Depth   = 2 ** ADDR_W;
  localparam bit          HasWait = (LATENCY != 0);
  localparam logic [3:0]  CntInit = (LATENCY == 0) ? 4'd0 : 4'(LATENCY - 1);

  typedef enum logic [0:0] {StIdle, StBusy} state_e;

  state_e            r_state, w_state_nxt;
  logic [3:0]        r_cnt, w_cnt_nxt;

  logic              w_req;
  logic              w_misaligned;
  logic              w_stall;
  logic              w_retire;
  logic              w_wr;
  logic              w_rd;
  logic [ADDR_W-1:0] w_index;

  logic [31:0]       r_mem [Depth];

  logic [1:0]        r_ctlwb;
  logic [31:0]       r_read_data;
  logic [31:0]       r_alu_result;
  logic [4:0]        r_muxout;
  logic              r_misalign;

  // Decode; upper address bits are dropped so addresses wrap modulo depth.
  always_comb begin
    w_req        = (ctlm_in != 2'b00);
    w_misaligned = w_req && (alu_result_in[1:0] != 2'b00);
    w_index      = alu_result_in[ADDR_W+1:2];
    w_wr         = ctlm_in[0] && !w_misaligned;
    w_rd         = (ctlm_in == 2'b10) && !w_misaligned;
  end

  always_comb begin
    w_stall  = ((r_state == StIdle) && w_req && !w_misaligned && HasWait) ||
               ((r_state == StBusy) && (r_cnt != 4'd0));
    w_retire = !w_stall;
  end

  assign stall_out = w_stall;

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    case (r_state)
      StIdle: begin
        if (w_stall) begin
          w_state_nxt = StBusy;
          w_cnt_nxt   = CntInit;
        end
      end
      StBusy: begin
        if (r_cnt != 4'd0) begin
          w_cnt_nxt = r_cnt - 4'd1;
        end else begin
          w_state_nxt = StIdle;
        end
      end
      default: begin
        w_state_nxt = StIdle;
        w_cnt_nxt   = 4'd0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= StIdle;
      r_cnt   <= 4'd0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  // Write only on the retire edge, and never while reset abandons an access.
  always_ff @(posedge clk) begin
    if (rst_n && w_retire && w_wr) begin
      r_mem[w_index] <= rdata2_in;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_ctlwb      <= 2'b00;
      r_read_data  <= 32'd0;
      r_alu_result <= 32'd0;
      r_muxout     <= 5'd0;
      r_misalign   <= 1'b0;
    end else if (w_retire) begin
      r_ctlwb      <= w_misaligned ? 2'b00 : ctlwb_in;
      r_read_data  <= w_rd ? r_mem[w_index] : 32'd0;
      r_alu_result <= alu_result_in;
      r_muxout     <= muxout_in;
      r_misalign   <= w_misaligned;
    end else begin
      // Bubble into WB while stalled; data fields hold.
      r_ctlwb    <= 2'b00;
      r_misalign <= 1'b0;
    end
  end

  assign ctlwb_out      = r_ctlwb;
  assign read_data_out  = r_read_data;
  assign alu_result_out = r_alu_result;
  assign muxout_out     = r_muxout;
  assign misalign_out   = r_misalign;

endmodule

// File: tb/tb_mem_stage.sv
// Bench for mem_stage: a LATENCY=2 and a LATENCY=0 instance driven from the same
// operations, checked against a transaction-level model of memory and retire timing.
module tb_mem_stage;

  localparam int LatA = 2;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [1:0]  ctlwb_in;
  logic [1:0]  ctlm_in;
  logic [31:0] alu_result_in;
  logic [31:0] rdata2_in;
  logic [4:0]  muxout_in;
  logic        b_en;
  logic [1:0]  ctlm_b;

  logic        stall_a, stall_b;
  logic [1:0]  ctlwb_a, ctlwb_b;
  logic [31:0] rd_a, rd_b, alu_a, alu_b;
  logic [4:0]  mux_a, mux_b;
  logic        mis_a, mis_b;

  int n_checks = 0;
  int n_fail   = 0;

  logic [31:0] mem_m [int];
  logic [31:0] exp_rd_a, exp_alu_a;
  logic [4:0]  exp_mux_a;

  always #5 clk = ~clk;

  assign ctlm_b = b_en ? ctlm_in : 2'b00;

  mem_stage #(.ADDR_W(8), .LATENCY(LatA)) dut_a (
    .clk(clk), .rst_n(rst_n), .ctlwb_in(ctlwb_in), .ctlm_in(ctlm_in),
    .alu_result_in(alu_result_in), .rdata2_in(rdata2_in), .muxout_in(muxout_in),
    .stall_out(stall_a), .ctlwb_out(ctlwb_a), .read_data_out(rd_a),
    .alu_result_out(alu_a), .muxout_out(mux_a), .misalign_out(mis_a)
  );

  mem_stage #(.ADDR_W(8), .LATENCY(0)) dut_b (
    .clk(clk), .rst_n(rst_n), .ctlwb_in(ctlwb_in), .ctlm_in(ctlm_b),
    .alu_result_in(alu_result_in), .rdata2_in(rdata2_in), .muxout_in(muxout_in),
    .stall_out(stall_b), .ctlwb_out(ctlwb_b), .read_data_out(rd_b),
    .alu_result_out(alu_b), .muxout_out(mux_b), .misalign_out(mis_b)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic [1:0] wb, input logic [1:0] m, input logic [31:0] alu,
                       input logic [31:0] rd2, input logic [4:0] mux, input bit b_on);
    ctlwb_in = wb; ctlm_in = m; alu_result_in = alu; rdata2_in = rd2; muxout_in = mux;
    b_en = b_on;
  endtask

  // One operation: LatA stall cycles for aligned accesses, then retire.
  task automatic do_op(input logic [1:0] wb, input logic [1:0] m, input logic [31:0] alu,
                       input logic [31:0] rd2, input logic [4:0] mux, input bit b_on);
    bit          req, mis, wr, rdonly, mis_b_e, rdonly_b;
    int          idx, n;
    logic [31:0] rdv, rdv_b;
    logic [1:0]  mb;
    req    = (m != 2'b00);
    mis    = req && (alu[1:0] != 2'b00);
    wr     = m[0] && !mis;
    rdonly = (m == 2'b10) && !mis;
    idx    = int'((alu >> 2) & 32'hFF);
    n      = (req && !mis) ? LatA : 0;
    mb       = b_on ? m : 2'b00;
    mis_b_e  = (mb != 2'b00) && (alu[1:0] != 2'b00);
    rdonly_b = (mb == 2'b10) && !mis_b_e;
    @(negedge clk);
    drive(wb, m, alu, rd2, mux, b_on);
    for (int k = 0; k <= n; k++) begin
      #1;
      chk("stall_a", 32'(stall_a), 32'(k < n));
      chk("stall_b", 32'(stall_b), 32'd0);
      rdv   = rdonly ? mem_m[idx] : 32'd0;
      rdv_b = rdonly_b ? mem_m[idx] : 32'd0;
      @(posedge clk);
      #1;
      if (k < n) begin
        chk("bubble_ctlwb_a", 32'(ctlwb_a), 32'd0);
        chk("bubble_mis_a", 32'(mis_a), 32'd0);
        chk("hold_rd_a", rd_a, exp_rd_a);
        chk("hold_alu_a", alu_a, exp_alu_a);
        chk("hold_mux_a", 32'(mux_a), 32'(exp_mux_a));
      end else begin
        if (wr) mem_m[idx] = rd2;
        exp_rd_a = rdv; exp_alu_a = alu; exp_mux_a = mux;
        chk("ctlwb_a", 32'(ctlwb_a), 32'(mis ? 2'b00 : wb));
        chk("mis_a", 32'(mis_a), 32'(mis));
        chk("rd_a", rd_a, exp_rd_a);
        chk("alu_a", alu_a, exp_alu_a);
        chk("mux_a", 32'(mux_a), 32'(exp_mux_a));
      end
      // The zero-latency instance retires (idempotently) on every edge.
      chk("ctlwb_b", 32'(ctlwb_b), 32'(mis_b_e ? 2'b00 : wb));
      chk("mis_b", 32'(mis_b), 32'(mis_b_e));
      chk("rd_b", rd_b, rdv_b);
      chk("alu_b", alu_b, alu);
      chk("mux_b", 32'(mux_b), 32'(mux));
      if (k < n) @(negedge clk);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    drive(2'b00, 2'b00, 32'd0, 32'd0, 5'd0, 1'b1);
    repeat (2) @(posedge clk);
    #1;
    chk("rst_stall_a", 32'(stall_a), 32'd0);
    chk("rst_ctlwb_a", 32'(ctlwb_a), 32'd0);
    chk("rst_rd_a", rd_a, 32'd0);
    chk("rst_alu_a", alu_a, 32'd0);
    chk("rst_mux_a", 32'(mux_a), 32'd0);
    chk("rst_mis_a", 32'(mis_a), 32'd0);
    chk("rst_ctlwb_b", 32'(ctlwb_b), 32'd0);
    chk("rst_rd_b", rd_b, 32'd0);
    exp_rd_a = 32'd0; exp_alu_a = 32'd0; exp_mux_a = 5'd0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    int          idx_list [8];
    logic [31:0] alu;
    logic [1:0]  lo;
    idx_list = '{0, 1, 2, 8'h10, 8'h55, 8'h80, 8'hFE, 8'hFF};
    rst_n = 1'b1;
    drive(2'b00, 2'b00, 32'd0, 32'd0, 5'd0, 1'b1);

    do_reset();

    // Store then load
    do_op(2'b00, 2'b01, 32'h10, 32'hDEADBEEF, 5'd0, 1'b1);
    do_op(2'b11, 2'b10, 32'h10, 32'd0, 5'h08, 1'b1);
    chk("lit_load", rd_a, 32'hDEADBEEF);
    chk("lit_load_wb", 32'(ctlwb_a), 32'd3);

    // ALU op
    do_op(2'b10, 2'b00, 32'h1234, 32'hAAAA, 5'h1A, 1'b1);
    chk("lit_alu", alu_a, 32'h1234);
    chk("lit_alu_rd", rd_a, 32'd0);

    // Misaligned load
    do_op(2'b11, 2'b10, 32'h13, 32'd0, 5'h3, 1'b1);
    chk("lit_mis", 32'(mis_a), 32'd1);

    // Wrap
    do_op(2'b00, 2'b01, 32'h400, 32'h55, 5'd0, 1'b1);
    do_op(2'b11, 2'b10, 32'h000, 32'd0, 5'h4, 1'b1);
    chk("lit_wrap", rd_a, 32'h55);

    // Both bits set: write only, no read data
    do_op(2'b11, 2'b11, 32'h8, 32'h77, 5'h5, 1'b1);
    do_op(2'b11, 2'b10, 32'h8, 32'd0, 5'h5, 1'b1);
    chk("lit_rw", rd_a, 32'h77);

    // Reset mid-BUSY abandons the store
    do_op(2'b00, 2'b01, 32'h20, 32'h0, 5'd0, 1'b1);
    @(negedge clk);
    drive(2'b00, 2'b01, 32'h20, 32'hFFFF, 5'd0, 1'b0);
    #1 chk("abort_stall0", 32'(stall_a), 32'd1);
    @(posedge clk);
    #1 chk("abort_stall1", 32'(stall_a), 32'd1);
    do_reset();
    #1 chk("abort_stall_after", 32'(stall_a), 32'd0);
    do_op(2'b11, 2'b10, 32'h20, 32'd0, 5'h9, 1'b1);
    chk("lit_abort", rd_a, 32'h0);

    // Initialise the random address pool, then random traffic
    foreach (idx_list[i]) do_op(2'b00, 2'b01, 32'(idx_list[i]) << 2, $urandom, 5'd0, 1'b1);
    for (int t = 0; t < 300; t++) begin
      lo  = ($urandom_range(0, 5) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
      alu = {$urandom, 2'b00};
      alu[9:2] = 8'(idx_list[$urandom_range(0, 7)]);
      alu[1:0] = lo;
      do_op(2'($urandom), 2'($urandom), alu, $urandom, 5'($urandom), 1'b1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
